hazard_stall_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage core pipeline. Drives the enables and flushes of
//  the PC register, the Fetch/Decode register and the Decode/Execute register. Covers load-use

---
 rtl/hazard_stall_ctrl_if.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard interface: Decode/Execute hazard inputs toward the
// stall/flush controller, and the pipeline-register controls it returns.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rd_e;
  logic             reg_write_e;
  logic             load_e;
  logic             mdu_start_e;
  logic             pc_src_e;
  logic             imem_ready;

  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic             stall_e;
  logic             mdu_busy;
  logic             imem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_d, rs2_d, rd_e, reg_write_e, load_e, mdu_start_e, pc_src_e, imem_ready,
    input  stall_f, stall_d, flush_d, flush_e, stall_e, mdu_busy, imem_err, stall_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rd_e, reg_write_e, load_e, mdu_start_e, pc_src_e, imem_ready,
    output stall_f, stall_d, flush_d, flush_e, stall_e, mdu_busy, imem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Drives PC / F-D / D-E register enables and flushes for load-use hazards,
// taken branches, imem wait states and multi-cycle MUL/DIV occupancy.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  RUN      | normal flow; a MUL/DIV start here stalls for its first cycle
//  MDU_BUSY | MUL/DIV still occupying Execute; front of pipe held
module hazard_stall_ctrl #(
  parameter int MDU_LAT      = 4,
  parameter int IMEM_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);

  // MDU counter holds MDU_LAT-2 at most; wait counter holds IMEM_TIMEOUT.
  localparam int MW = (MDU_LAT > 3) ? $clog2(MDU_LAT - 1) : 1;
  localparam int WW = $clog2(IMEM_TIMEOUT + 1);
  localparam bit MDU_MULTI = (MDU_LAT > 1);
  localparam logic [MW-1:0] MDU_LOAD = MW'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);
  localparam logic [WW-1:0] WAIT_MAX = WW'(IMEM_TIMEOUT);

  typedef enum logic [0:0] {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             imem_err_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic mdu_act;
  logic load_use;
  logic stall_f, stall_d, flush_d, flush_e, stall_e;

  // State and MDU occupancy counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // Next-state, hazard priority resolution and stall/flush outputs.
  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    stall_e   = 1'b0;

    load_use = bus.reg_write_e && bus.load_e && (bus.rd_e != 5'd0) &&
               ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));
    mdu_act  = (state_q == MDU_BUSY) || (bus.mdu_start_e && MDU_MULTI);

    case (state_q)
      RUN: begin
        if (bus.mdu_start_e && MDU_MULTI) begin
          state_d   = MDU_BUSY;
          mdu_cnt_d = MDU_LOAD;
        end
      end
      MDU_BUSY: begin
        if (mdu_cnt_q == '0) state_d = RUN;
        else                 mdu_cnt_d = mdu_cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Outputs are forced low while reset is held, independent of inputs.
    if (rst) begin
      if (mdu_act) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
      end else if (bus.pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        if (!bus.imem_ready) begin
          stall_f = 1'b1;
          flush_d = !load_use;
        end
      end
    end
  end

  // Imem watchdog: saturating wait counter, saturating value sets the sticky error.
  always_comb begin
    wait_d = wait_q;
    if (bus.imem_ready)          wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
  end

  // Watchdog and stall performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q      <= '0;
      imem_err_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      wait_q <= wait_d;
      if (wait_d == WAIT_MAX) imem_err_q <= 1'b1;
      if (stall_f && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall_f   = stall_f;
  assign bus.stall_d   = stall_d;
  assign bus.flush_d   = flush_d;
  assign bus.flush_e   = flush_e;
  assign bus.stall_e   = stall_e;
  assign bus.mdu_busy  = rst && (state_q == MDU_BUSY);
  assign bus.imem_err  = imem_err_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: main instance with default parameters,
// plus a small instance (MDU_LAT=1, IMEM_TIMEOUT=4, CNT_W=3) sharing its inputs.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  hazard_stall_ctrl_if #(.CNT_W(32)) bus  ();
  hazard_stall_ctrl_if #(.CNT_W(3))  bus2 ();

  hazard_stall_ctrl #(.MDU_LAT(4), .IMEM_TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  hazard_stall_ctrl #(.MDU_LAT(1), .IMEM_TIMEOUT(4), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  assign bus2.rs1_d       = bus.rs1_d;
  assign bus2.rs2_d       = bus.rs2_d;
  assign bus2.rd_e        = bus.rd_e;
  assign bus2.reg_write_e = bus.reg_write_e;
  assign bus2.load_e      = bus.load_e;
  assign bus2.mdu_start_e = bus.mdu_start_e;
  assign bus2.pc_src_e    = bus.pc_src_e;
  assign bus2.imem_ready  = bus.imem_ready;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1_d = 5'd0; bus.rs2_d = 5'd0; bus.rd_e = 5'd0;
    bus.reg_write_e = 1'b0; bus.load_e = 1'b0; bus.mdu_start_e = 1'b0;
    bus.pc_src_e = 1'b0; bus.imem_ready = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    bus.reg_write_e = 1'b1; bus.load_e = 1'b1;
    bus.rd_e = rd; bus.rs1_d = r1; bus.rs2_d = r2;
  endtask

  initial begin
    idle();
    bus.imem_ready = 1'b0;
    bus.pc_src_e   = 1'b1;
    #2;
    chk("rst_stall_f",  64'(bus.stall_f), 64'd0);
    chk("rst_flush_d",  64'(bus.flush_d), 64'd0);
    chk("rst_flush_e",  64'(bus.flush_e), 64'd0);
    chk("rst_cnt",      64'(bus.stall_cnt), 64'd0);
    chk("rst_err",      64'(bus.imem_err), 64'd0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("idle_stall_f", 64'(bus.stall_f), 64'd0);
    chk("idle_busy",    64'(bus.mdu_busy), 64'd0);
    tick();

    // Load-use on rs1
    set_load_use(5'd5, 5'd5, 5'd0);
    #1;
    chk("lu_stall_f", 64'(bus.stall_f), 64'd1);
    chk("lu_stall_d", 64'(bus.stall_d), 64'd1);
    chk("lu_flush_e", 64'(bus.flush_e), 64'd1);
    chk("lu_flush_d", 64'(bus.flush_d), 64'd0);
    chk("lu_stall_e", 64'(bus.stall_e), 64'd0);
    tick();
    idle();
    #1;
    chk("lu_released", 64'(bus.stall_f), 64'd0);
    chk("lu_cnt",      64'(bus.stall_cnt), 64'd1);

    // rd_e = x0 never hazards
    set_load_use(5'd0, 5'd0, 5'd0);
    #1;
    chk("lu_x0_stall_f", 64'(bus.stall_f), 64'd0);
    chk("lu_x0_flush_e", 64'(bus.flush_e), 64'd0);
    tick();
    // Load-use on rs2
    set_load_use(5'd7, 5'd3, 5'd7);
    #1;
    chk("lu_rs2_stall_d", 64'(bus.stall_d), 64'd1);
    tick();
    // Not a load: no hazard
    set_load_use(5'd7, 5'd7, 5'd0);
    bus.load_e = 1'b0;
    #1;
    chk("noload_stall_f", 64'(bus.stall_f), 64'd0);
    tick();
    idle();
    #1;
    chk("cnt_after_lu", 64'(bus.stall_cnt), 64'd2);

    // MDU op, MDU_LAT=4: start cycle + 3 busy cycles
    bus.mdu_start_e = 1'b1;
    #1;
    chk("mdu_start_stall_e", 64'(bus.stall_e), 64'd1);
    chk("mdu_start_stall_f", 64'(bus.stall_f), 64'd1);
    chk("mdu_start_busy",    64'(bus.mdu_busy), 64'd0);
    chk("lat1_no_stall",     64'(bus2.stall_e), 64'd0);
    tick();
    bus.mdu_start_e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) bus.pc_src_e = 1'b1;
      #1;
      chk("mdu_busy",    64'(bus.mdu_busy), 64'd1);
      chk("mdu_stall_e", 64'(bus.stall_e), 64'd1);
      chk("mdu_stall_d", 64'(bus.stall_d), 64'd1);
      chk("mdu_flush_d", 64'(bus.flush_d), 64'd0);
      chk("mdu_flush_e", 64'(bus.flush_e), 64'd0);
      tick();
      bus.pc_src_e = 1'b0;
    end
    #1;
    chk("mdu_done_busy",  64'(bus.mdu_busy), 64'd0);
    chk("mdu_done_stall", 64'(bus.stall_e), 64'd0);
    chk("mdu_cnt",        64'(bus.stall_cnt), 64'd6);

    // Branch with load-use and imem wait in the same cycle
    set_load_use(5'd9, 5'd9, 5'd0);
    bus.pc_src_e   = 1'b1;
    bus.imem_ready = 1'b0;
    #1;
    chk("br_flush_d", 64'(bus.flush_d), 64'd1);
    chk("br_flush_e", 64'(bus.flush_e), 64'd1);
    chk("br_stall_f", 64'(bus.stall_f), 64'd0);
    chk("br_stall_d", 64'(bus.stall_d), 64'd0);
    tick();
    idle();
    tick();

    // Load-use and imem wait together: stall_d wins over flush_d
    set_load_use(5'd4, 5'd0, 5'd4);
    bus.imem_ready = 1'b0;
    #1;
    chk("luw_stall_f", 64'(bus.stall_f), 64'd1);
    chk("luw_stall_d", 64'(bus.stall_d), 64'd1);
    chk("luw_flush_d", 64'(bus.flush_d), 64'd0);
    chk("luw_flush_e", 64'(bus.flush_e), 64'd1);
    tick();
    idle();
    tick();
    #1;
    chk("cnt_before_wd", 64'(bus.stall_cnt), 64'd7);

    // Watchdog: 64 consecutive not-ready cycles
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("wd_stall_f", 64'(bus.stall_f), 64'd1);
      chk("wd_flush_d", 64'(bus.flush_d), 64'd1);
      chk("wd_err_low", 64'(bus.imem_err), 64'd0);
      if (i == 4) chk("wd2_err", 64'(bus2.imem_err), 64'd1);
      tick();
    end
    #1;
    chk("wd_err_set", 64'(bus.imem_err), 64'd1);
    chk("wd2_cnt_sat", 64'(bus2.stall_cnt), 64'd7);
    bus.imem_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("wd_err_sticky", 64'(bus.imem_err), 64'd1);
    chk("wd_stall_f_off", 64'(bus.stall_f), 64'd0);
    chk("wd_cnt", 64'(bus.stall_cnt), 64'd71);

    // Reset two cycles into an MDU stall
    bus.mdu_start_e = 1'b1;
    tick();
    bus.mdu_start_e = 1'b0;
    tick();
    #1;
    chk("pre_rst_busy", 64'(bus.mdu_busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall_f", 64'(bus.stall_f), 64'd0);
    chk("mid_rst_stall_e", 64'(bus.stall_e), 64'd0);
    chk("mid_rst_busy",    64'(bus.mdu_busy), 64'd0);
    chk("mid_rst_err",     64'(bus.imem_err), 64'd0);
    chk("mid_rst_cnt",     64'(bus.stall_cnt), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_busy",    64'(bus.mdu_busy), 64'd0);
    chk("post_rst_stall_e", 64'(bus.stall_e), 64'd0);
    tick();
    #1;
    chk("post_rst_cnt", 64'(bus.stall_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
